// File: rtl/date_pkg.sv
// Shared definitions for the calendar stage: month codes, BCD digit type,
// output width, set-FSM states and the date-packing helpers used for both
// the live outputs and the reset constants.
package date_pkg;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    localparam int DATE_NUM_W = 40;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        APPLY  = 2'd2,
        REJECT = 2'd3
    } set_state_t;

    // Gregorian leap rule.
    function automatic logic is_leap(input logic [13:0] y);
        return ((y % 14'd4 == 14'd0) && (y % 14'd100 != 14'd0)) || (y % 14'd400 == 14'd0);
    endfunction

    // Decimal digit of v at the position selected by div (1, 10, 100, 1000).
    function automatic bcd_digit_t digit_of(input logic [13:0] v, input logic [13:0] div);
        logic [13:0] q;
        q = (v / div) % 14'd10;
        return q[3:0];
    endfunction

    // Packed {Y3,Y2,Y1,Y0,M1,M0,D1,D0}.
    function automatic logic [31:0] bcd_pack(input logic [13:0] y, input logic [3:0] m,
                                             input logic [4:0] d);
        return {digit_of(y, 14'd1000), digit_of(y, 14'd100),
                digit_of(y, 14'd10), digit_of(y, 14'd1),
                digit_of({10'd0, m}, 14'd10), digit_of({10'd0, m}, 14'd1),
                digit_of({9'd0, d}, 14'd10), digit_of({9'd0, d}, 14'd1)};
    endfunction

    // year*10000 + month*100 + day.
    function automatic logic [DATE_NUM_W-1:0] num_pack(input logic [13:0] y, input logic [3:0] m,
                                                       input logic [4:0] d);
        return ({26'd0, y} * 40'd10000) + ({36'd0, m} * 40'd100) + {35'd0, d};
    endfunction

endpackage

// File: rtl/date_counter_days_in_month.sv
// Combinational month length lookup, leap years included.
// An illegal month code yields 0 so that no day can pass a range check against it.
module days_in_month
    import date_pkg::*;
(
    input  logic [13:0] year,
    input  logic [3:0]  month,
    output logic [4:0]  dim
);

    // Month length from month code and leap status of the year.
    always_comb begin
        dim = 5'd0;
        case (month)
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: dim = 5'd31;
            APR, JUN, SEP, NOV:                dim = 5'd30;
            FEB: begin
                if (is_leap(year)) begin
                    dim = 5'd29;
                end else begin
                    dim = 5'd28;
                end
            end
            default: dim = 5'd0;
        endcase
    end

endmodule

// File: rtl/date_counter.sv
// Calendar stage: holds year/month/day, advances on day_tick, optionally accepts
// a validated date-set request, and presents registered YYYYMMDD binary and BCD.
// Optional feature macro: DATE_SET_EN (set handshake and checking FSM).
module date_counter
    import date_pkg::*;
#(
    parameter int RESET_YEAR  = 2023,
    parameter int RESET_MONTH = 5,
    parameter int RESET_DAY   = 5,
    parameter int YEAR_MIN    = 2000,
    parameter int YEAR_MAX    = 2099
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  day_tick,
    input  logic                  set_valid,
    output logic                  set_ready,
    input  logic [13:0]           set_year,
    input  logic [3:0]            set_month,
    input  logic [4:0]            set_day,
    output logic                  set_ack,
    output logic                  set_err,
    output logic [DATE_NUM_W-1:0] date_num,
    output logic [31:0]           date_bcd,
    output logic                  date_upd
);

    localparam logic [13:0] Y_MIN   = 14'(YEAR_MIN);
    localparam logic [13:0] Y_MAX   = 14'(YEAR_MAX);
    localparam logic [13:0] RST_Y   = 14'(RESET_YEAR);
    localparam logic [3:0]  RST_M   = 4'(RESET_MONTH);
    localparam logic [4:0]  RST_D   = 5'(RESET_DAY);
    localparam logic [DATE_NUM_W-1:0] RST_NUM = num_pack(RST_Y, RST_M, RST_D);
    localparam logic [31:0] RST_BCD = bcd_pack(RST_Y, RST_M, RST_D);

    logic [13:0] year_r;
    logic [3:0]  month_r;
    logic [4:0]  day_r;
    logic        date_chg_r;   // date registers changed at the last edge
    logic [4:0]  dim_cur_s;
    logic [13:0] adv_year_s;
    logic [3:0]  adv_month_s;
    logic [4:0]  adv_day_s;

    days_in_month u_dim_cur (
        .year  (year_r),
        .month (month_r),
        .dim   (dim_cur_s)
    );

    // Next-day value of the current date, including month/year roll and year wrap.
    always_comb begin
        adv_year_s  = year_r;
        adv_month_s = month_r;
        adv_day_s   = day_r;
        if (day_r < dim_cur_s) begin
            adv_day_s = day_r + 5'd1;
        end else begin
            adv_day_s = 5'd1;
            if (month_r >= DEC) begin
                adv_month_s = JAN;
                if (year_r >= Y_MAX) begin
                    adv_year_s = Y_MIN;
                end else begin
                    adv_year_s = year_r + 14'd1;
                end
            end else begin
                adv_month_s = month_r + 4'd1;
            end
        end
    end

`ifdef DATE_SET_EN
    set_state_t  state_r;
    logic        set_ready_r;
    logic        pend_r;       // one deferred day_tick
    logic        done_r;       // request finished; becomes set_ack one edge later
    logic        err_r;
    logic [13:0] set_year_r;
    logic [3:0]  set_month_r;
    logic [4:0]  set_day_r;
    logic [4:0]  dim_set_s;
    logic        legal_s;
    logic        accept_s;

    days_in_month u_dim_set (
        .year  (set_year_r),
        .month (set_month_r),
        .dim   (dim_set_s)
    );

    // Legality of the latched request and handshake acceptance.
    always_comb begin
        legal_s  = (set_year_r >= Y_MIN) && (set_year_r <= Y_MAX) &&
                   (set_month_r >= JAN) && (set_month_r <= DEC) &&
                   (set_day_r >= 5'd1) && (set_day_r <= dim_set_s);
        accept_s = (state_r == IDLE) && set_valid && set_ready_r;
    end

    // Set FSM together with the date registers and the deferred-tick flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            set_ready_r <= 1'b1;
            pend_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            date_chg_r  <= 1'b0;
            set_year_r  <= 14'd0;
            set_month_r <= 4'd0;
            set_day_r   <= 5'd0;
            year_r      <= RST_Y;
            month_r     <= RST_M;
            day_r       <= RST_D;
        end else begin
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            date_chg_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A pending tick advances the current date; a tick arriving
                    // with an accepted request waits until the set completes.
                    if (accept_s) begin
                        set_year_r  <= set_year;
                        set_month_r <= set_month;
                        set_day_r   <= set_day;
                        state_r     <= CHECK;
                        set_ready_r <= 1'b0;
                        pend_r      <= day_tick;
                    end else begin
                        pend_r <= 1'b0;
                    end
                    if (pend_r || (day_tick && !accept_s)) begin
                        year_r     <= adv_year_s;
                        month_r    <= adv_month_s;
                        day_r      <= adv_day_s;
                        date_chg_r <= 1'b1;
                    end else begin
                        date_chg_r <= 1'b0;
                    end
                end
                CHECK: begin
                    state_r <= legal_s ? APPLY : REJECT;
                    if (day_tick) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                APPLY: begin
                    year_r      <= set_year_r;
                    month_r     <= set_month_r;
                    day_r       <= set_day_r;
                    date_chg_r  <= 1'b1;
                    done_r      <= 1'b1;
                    state_r     <= IDLE;
                    set_ready_r <= 1'b1;
                    if (day_tick) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                REJECT: begin
                    done_r      <= 1'b1;
                    err_r       <= 1'b1;
                    state_r     <= IDLE;
                    set_ready_r <= 1'b1;
                    if (day_tick) begin
                        pend_r <= 1'b1;
                    end else begin
                        pend_r <= pend_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    set_ready_r <= 1'b1;
                    pend_r      <= 1'b0;
                end
            endcase
        end
    end

    assign set_ready = set_ready_r;

    // Handshake completion flags, aligned with the output date registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            set_ack <= 1'b0;
            set_err <= 1'b0;
        end else begin
            set_ack <= done_r;
            set_err <= err_r;
        end
    end
`else
    logic unused_set_s;
    assign unused_set_s = ^{set_valid, set_year, set_month, set_day};

    // Date registers advanced directly by day_tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            year_r     <= RST_Y;
            month_r    <= RST_M;
            day_r      <= RST_D;
            date_chg_r <= 1'b0;
        end else if (day_tick) begin
            year_r     <= adv_year_s;
            month_r    <= adv_month_s;
            day_r      <= adv_day_s;
            date_chg_r <= 1'b1;
        end else begin
            date_chg_r <= 1'b0;
        end
    end

    assign set_ready = 1'b0;
    assign set_ack   = 1'b0;
    assign set_err   = 1'b0;
`endif

    // Registered presentation of the date one edge after the date registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            date_num <= RST_NUM;
            date_bcd <= RST_BCD;
            date_upd <= 1'b0;
        end else begin
            date_num <= num_pack(year_r, month_r, day_r);
            date_bcd <= bcd_pack(year_r, month_r, day_r);
            date_upd <= date_chg_r;
        end
    end

endmodule
